// File: rtl/slice_packer_if.sv
// slice_packer_if: field-stream input and word-stream output of the slice packer
//   in_data/in_last/in_valid/in_ready : one slice field per beat toward the packer
//   out_data/out_valid/out_ready      : assembled 16-bit words from the packer
//   master : producer/consumer side; slave : packer side
interface slice_packer_if;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (output in_data, in_last, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave (input in_data, in_last, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/slice_packer.sv
// slice_packer: rebuilds 16-bit words from the three-field slice stream
//   clk, arst  : clock, asynchronous active-high reset
//   bus        : field input / word output streams (slave side)
//   frame_err  : sticky framing-error flag, cleared by err_clr
//   word_count : words delivered on the output, wraps at 2^16
module slice_packer #(
    parameter bit SWAP_F0 = 1'b1
) (
    input  logic        clk,
    input  logic        arst,
    slice_packer_if.slave bus,
    output logic        frame_err,
    input  logic        err_clr,
    output logic [15:0] word_count
);
    typedef enum logic [1:0] {F0, F1, F2} state_t;
    state_t state, state_nxt;
    logic [7:0] hold, hold_nxt;
    logic accept, deliver, complete, viol;
    // Only the completing beat needs the output slot, so back-pressure applies in F2 alone.
    assign bus.in_ready = (state != F2) || !bus.out_valid || bus.out_ready;
    assign accept = bus.in_valid & bus.in_ready;
    assign deliver = bus.out_valid & bus.out_ready;
    always_comb begin
        state_nxt = state;
        hold_nxt = hold;
        complete = 1'b0;
        viol = 1'b0;
        if (accept) begin
            case (state)
                F0: begin
                    viol = bus.in_last;
                    state_nxt = bus.in_last ? F0 : F1;
                    if (!bus.in_last)
                        hold_nxt[3:0] = SWAP_F0 ? {bus.in_data[1:0], bus.in_data[3:2]} : bus.in_data[3:0];
                end
                F1: begin
                    viol = bus.in_last;
                    state_nxt = bus.in_last ? F0 : F2;
                    if (!bus.in_last)
                        hold_nxt[7:4] = bus.in_data[3:0];
                end
                default: begin
                    complete = bus.in_last;
                    viol = !bus.in_last;
                    state_nxt = F0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= F0;
            hold <= '0;
            bus.out_data <= '0;
            bus.out_valid <= 1'b0;
            frame_err <= 1'b0;
            word_count <= '0;
        end else begin
            state <= state_nxt;
            hold <= hold_nxt;
            if (complete)
                bus.out_data <= {bus.in_data, hold};
            bus.out_valid <= complete | (bus.out_valid & ~bus.out_ready);
            frame_err <= viol | (frame_err & ~err_clr);
            word_count <= word_count + {15'd0, deliver};
        end
    end
endmodule
